cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
Multi-cycle sequencer for the RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback, driving enables for the PC, IR, register file and a single shared memory port. It consumes the decoded control signals (reg_write, mem_read, mem_write, branch, jump) from the control unit. It also provides a retired-instruction counter, a halt handshake and a memory-timeout fault.

Parameters:
MEM_TIMEOUT, 16, max cycles a memory request may wait for mem_ready before FAULT (≥2)
INSTRET_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
reg_write  in  1  decoded: instruction writes rd
mem_read  in  1  decoded: load
mem_write  in  1  decoded: store
branch  in  1  decoded: conditional branch
jump  in  1  decoded: JAL
illegal  in  1  decoded: opcode unsupported (valid in DECODE)
branch_taken  in  1  ALU comparison result (valid in EXECUTE)
mem_ready  in  1  memory completes current request this cycle
halt_req  in  1  debug halt request
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  request is a write
addr_sel  out  1  0 = PC address, 1 = ALU result address
ir_load  out  1  latch fetched word into IR
pc_write  out  1  update PC this cycle
pc_src  out  1  0 = PC+4, 1 = branch/jump target
rf_we  out  1  register-file write enable
halted  out  1  sequencer parked in HALTED
fault  out  1  sticky fault flag
state  out  3  current state, for debug
instret  out  INSTRET_W  retired-instruction count

Behaviour:
- States: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, HALTED=5, FAULT=6. All outputs are Moore outputs from the state, except where noted.
- Reset (async, rst_n=0): state=FETCH, instret=0, fault=0, wait counter=0, and every output low.
- FETCH:
  - If halt_req=1 on entry cycle (before any mem_req cycle has elapsed), go to HALTED and issue no request.
  - Otherwise mem_req=1, mem_we=0, addr_sel=0.
  - When mem_ready=1: ir_load=1 (Mealy, same cycle), then DECODE.
- DECODE: one cycle. illegal=1 → FAULT; otherwise → EXECUTE.
- EXECUTE: one cycle.
  - mem_read or mem_write → MEM.
  - Else reg_write → WB.
  - Else: pc_write=1, pc_src=branch&branch_taken, instret++, then FETCH.
- MEM: mem_req=1, addr_sel=1, mem_we=mem_write. On mem_ready=1:
  - Load → WB.
  - Store → pc_write=1, pc_src=0, instret++, then FETCH.
- WB: rf_we=1, pc_write=1, pc_src=jump, instret++, then FETCH.
- Simple decode precedence: mem_write beats mem_read if both are set. mem_read and mem_write take precedence over branch/jump.
- Wait counter:
  - Clears whenever a state is entered.
  - Increments each FETCH/MEM cycle with mem_ready=0.
  - When it reaches MEM_TIMEOUT-1 with mem_ready still 0 → FAULT next cycle.
  - mem_ready on that same final cycle wins: normal completion, no fault.
- HALTED: halted=1, no requests. Returns to FETCH the cycle after halt_req=0. The PC is not modified.
- FAULT: fault=1, all enables low. Terminal until rst_n is asserted.
- instret wraps modulo 2^INSTRET_W and increments exactly once per pc_write.
- halt_req is ignored outside the FETCH entry cycle, so an in-flight instruction always completes.
- Reset mid-request drops mem_req immediately (asynchronously).
- Latencies with zero-wait memory:
  - ALU/JAL: 4 cycles (FETCH, DECODE, EXECUTE, WB).
  - Branch: 3 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.

Decomposition:
- Package cpu_seq_pkg holds: state encodings, PC_SRC_SEQ/PC_SRC_TGT, ADDR_PC/ADDR_ALU constants.
- Sub-module mem_wait_timer holds: wait counter plus timeout compare, with inputs clear/count and output expired.

Test Plan:
- ADDI (reg_write=1), mem_ready always 1 → FETCH, DECODE, EXECUTE, WB. rf_we and pc_write pulse once in WB with pc_src=0. instret 0→1.
- LW with mem_ready delayed 3 cycles in MEM → mem_req held 4 cycles with addr_sel=1 and mem_we=0. Then WB with rf_we=1. Total 8 cycles.
- BEQ: branch_taken=1 → pc_write with pc_src=1 in EXECUTE, rf_we never high. branch_taken=0 → pc_src=0.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH → FAULT after 4 request cycles. fault=1 and held. rst_n pulse clears everything to FETCH.
- halt_req=1 at FETCH entry → halted=1 with no mem_req. Deassert halt_req → next cycle FETCH, mem_req=1. halt_req raised mid-SW → the store completes, instret increments, then HALTED.
- illegal=1 in DECODE → FAULT. INSTRET_W=4 with 16 retires → instret wraps to 0.

Source files
------------

// File: rtl/cpu_seq_pkg.sv
// Shared encodings for the multi-cycle RV32I sequencer: state codes,
// PC source and address-mux selections, and the bundle of control strobes
// the sequencer produces each cycle.
package cpu_seq_pkg;

  // Sequencer states; the numeric values are visible on the debug port.
  localparam logic [2:0] ST_FETCH   = 3'd0;
  localparam logic [2:0] ST_DECODE  = 3'd1;
  localparam logic [2:0] ST_EXECUTE = 3'd2;
  localparam logic [2:0] ST_MEM     = 3'd3;
  localparam logic [2:0] ST_WB      = 3'd4;
  localparam logic [2:0] ST_HALTED  = 3'd5;
  localparam logic [2:0] ST_FAULT   = 3'd6;

  // Next-PC mux: sequential PC+4 or branch/jump target.
  localparam logic PC_SRC_SEQ = 1'b0;
  localparam logic PC_SRC_TGT = 1'b1;

  // Memory address mux: PC for instruction fetch, ALU result for data.
  localparam logic ADDR_PC  = 1'b0;
  localparam logic ADDR_ALU = 1'b1;

  // Per-cycle datapath strobes driven by the sequencer.
  typedef struct packed {
    logic mem_req;
    logic mem_we;
    logic addr_sel;
    logic ir_load;
    logic pc_write;
    logic pc_src;
    logic rf_we;
  } seq_ctrl_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts how long the current memory request has been stalled and flags
// the cycle on which the wait budget runs out.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int CW = $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] wait_cnt;

  // The budget is spent only when the last allowed cycle also stalls, so a
  // ready arriving on that cycle (count low) still completes normally.
  assign expired = count && (wait_cnt == LAST);

  // Stall counter: restarts on every state entry, advances on stalled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (clear) begin
      wait_cnt <= '0;
    end else if (count && !expired) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for the RV32I core: walks each instruction
// through fetch, decode, execute, memory and writeback, drives the PC/IR/
// register-file enables and the shared memory port, counts retirements,
// supports a debug halt at instruction boundaries and faults on a stuck
// memory or an illegal opcode.
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int INSTRET_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 reg_write,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic                 branch,
  input  logic                 jump,
  input  logic                 illegal,
  input  logic                 branch_taken,
  input  logic                 mem_ready,
  input  logic                 halt_req,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 addr_sel,
  output logic                 ir_load,
  output logic                 pc_write,
  output logic                 pc_src,
  output logic                 rf_we,
  output logic                 halted,
  output logic                 fault,
  output logic [2:0]           state,
  output logic [INSTRET_W-1:0] instret
);

  logic [2:0]           state_q;
  logic [2:0]           state_next;
  logic                 entry_q;
  logic                 state_change;
  logic                 wait_count;
  logic                 timer_expired;
  seq_ctrl_t            ctrl;
  logic [INSTRET_W-1:0] instret_q;

  assign state_change = (state_next != state_q);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state_change),
    .count  (wait_count),
    .expired(timer_expired)
  );

  // Next-state and strobe decode; a few strobes depend on the current
  // inputs so that a completing request is acted on in the same cycle.
  always_comb begin
    ctrl       = '0;
    state_next = state_q;
    wait_count = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (entry_q && halt_req) begin
          state_next = ST_HALTED;
        end else begin
          ctrl.mem_req  = 1'b1;
          ctrl.addr_sel = ADDR_PC;
          wait_count    = !mem_ready;
          if (mem_ready) begin
            ctrl.ir_load = 1'b1;
            state_next   = ST_DECODE;
          end else if (timer_expired) begin
            state_next = ST_FAULT;
          end
        end
      end

      ST_DECODE: begin
        state_next = illegal ? ST_FAULT : ST_EXECUTE;
      end

      ST_EXECUTE: begin
        if (mem_write || mem_read) begin
          state_next = ST_MEM;
        end else if (reg_write) begin
          state_next = ST_WB;
        end else begin
          ctrl.pc_write = 1'b1;
          ctrl.pc_src   = (branch && branch_taken) ? PC_SRC_TGT : PC_SRC_SEQ;
          state_next    = ST_FETCH;
        end
      end

      ST_MEM: begin
        ctrl.mem_req  = 1'b1;
        ctrl.addr_sel = ADDR_ALU;
        ctrl.mem_we   = mem_write;
        wait_count    = !mem_ready;
        if (mem_ready) begin
          if (mem_write) begin
            ctrl.pc_write = 1'b1;
            ctrl.pc_src   = PC_SRC_SEQ;
            state_next    = ST_FETCH;
          end else begin
            state_next = ST_WB;
          end
        end else if (timer_expired) begin
          state_next = ST_FAULT;
        end
      end

      ST_WB: begin
        ctrl.rf_we    = 1'b1;
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = jump ? PC_SRC_TGT : PC_SRC_SEQ;
        state_next    = ST_FETCH;
      end

      ST_HALTED: begin
        if (!halt_req) begin
          state_next = ST_FETCH;
        end
      end

      ST_FAULT: begin
        state_next = ST_FAULT;
      end

      default: begin
        state_next = ST_FAULT;
      end
    endcase
  end

  // State register plus a flag marking the first cycle spent in a state,
  // which is the only point where a halt request is honoured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      entry_q <= 1'b1;
    end else begin
      state_q <= state_next;
      entry_q <= state_change;
    end
  end

  // Retired-instruction counter: one tick per PC update, wrapping freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= '0;
    end else if (ctrl.pc_write) begin
      instret_q <= instret_q + 1'b1;
    end
  end

  // Strobes are masked by reset so an in-flight request drops the instant
  // reset is asserted, not at the next clock edge.
  assign mem_req  = rst_n & ctrl.mem_req;
  assign mem_we   = rst_n & ctrl.mem_we;
  assign addr_sel = rst_n & ctrl.addr_sel;
  assign ir_load  = rst_n & ctrl.ir_load;
  assign pc_write = rst_n & ctrl.pc_write;
  assign pc_src   = rst_n & ctrl.pc_src;
  assign rf_we    = rst_n & ctrl.rf_we;
  assign halted   = (state_q == ST_HALTED);
  assign fault    = (state_q == ST_FAULT);
  assign state    = state_q;
  assign instret  = instret_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with a retire scoreboard: each issued
// instruction pushes its expected retirement profile, and a monitor pops
// and compares it whenever the sequencer pulses pc_write.
module tb_cpu_sequencer;
  import cpu_seq_pkg::*;

  localparam int MEM_TIMEOUT = 4;
  localparam int INSTRET_W   = 4;
  localparam int WRAP        = 1 << INSTRET_W;

  localparam int K_ALU    = 0;
  localparam int K_LOAD   = 1;
  localparam int K_STORE  = 2;
  localparam int K_BRANCH = 3;
  localparam int K_JAL    = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic reg_write = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic branch = 1'b0, jump = 1'b0, illegal = 1'b0, branch_taken = 1'b0;
  logic mem_ready = 1'b0, halt_req = 1'b0;
  logic mem_req, mem_we, addr_sel, ir_load, pc_write, pc_src, rf_we;
  logic halted, fault;
  logic [2:0] state;
  logic [INSTRET_W-1:0] instret;

  typedef struct {
    int seq;
    int pc_src;
    int rf_cnt;
    int latency;
    int req_cyc;
    int we_cyc;
    int alu_cyc;
    int ir_cnt;
    int retire_state;
    int instret_old;
  } retire_t;

  retire_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int retired = 0;
  int issued = 0;
  bit start_flag = 1'b0;
  int acc_cyc, acc_req, acc_we, acc_alu, acc_rf, acc_ir;

  always #5 clk = ~clk;

  cpu_sequencer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .INSTRET_W  (INSTRET_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .reg_write   (reg_write),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .branch      (branch),
    .jump        (jump),
    .illegal     (illegal),
    .branch_taken(branch_taken),
    .mem_ready   (mem_ready),
    .halt_req    (halt_req),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .addr_sel    (addr_sel),
    .ir_load     (ir_load),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .rf_we       (rf_we),
    .halted      (halted),
    .fault       (fault),
    .state       (state),
    .instret     (instret)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one instruction through a hand-scripted cycle sequence and
  // pushes the retirement profile the sequencer should produce for it.
  task automatic applyStimulus(input int kind, input int fw, input int mw,
                               input bit taken, input bit halt_mid);
    retire_t e;
    bit is_mem;
    bit has_wb;
    is_mem = (kind == K_LOAD) || (kind == K_STORE);
    has_wb = (kind == K_ALU) || (kind == K_LOAD) || (kind == K_JAL);
    e.seq          = issued;
    e.pc_src       = (kind == K_BRANCH) ? int'(taken) : ((kind == K_JAL) ? 1 : 0);
    e.rf_cnt       = has_wb ? 1 : 0;
    e.latency      = (fw + 1) + 2 + (is_mem ? mw + 1 : 0) + (has_wb ? 1 : 0);
    e.req_cyc      = (fw + 1) + (is_mem ? mw + 1 : 0);
    e.we_cyc       = (kind == K_STORE) ? mw + 1 : 0;
    e.alu_cyc      = is_mem ? mw + 1 : 0;
    e.ir_cnt       = 1;
    e.retire_state = has_wb ? 4 : ((kind == K_STORE) ? 3 : 2);
    e.instret_old  = retired % WRAP;
    exp_q.push_back(e);
    issued++;
    retired++;

    reg_write    = (kind == K_ALU) || (kind == K_LOAD) || (kind == K_JAL);
    mem_read     = (kind == K_LOAD);
    mem_write    = (kind == K_STORE);
    branch       = (kind == K_BRANCH);
    jump         = (kind == K_JAL);
    branch_taken = taken;
    illegal      = 1'b0;
    halt_req     = 1'b0;
    start_flag   = 1'b1;

    for (int i = 0; i < fw; i++) begin
      mem_ready = 1'b0;
      tick();
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    if (halt_mid) halt_req = 1'b1;
    tick();
    tick();
    if (is_mem) begin
      for (int i = 0; i < mw; i++) begin
        mem_ready = 1'b0;
        tick();
      end
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
    end
    if (has_wb) tick();
    reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    branch = 1'b0; jump = 1'b0; branch_taken = 1'b0;
  endtask

  // Retire monitor: accumulates per-instruction activity and checks it
  // against the oldest outstanding expectation on every pc_write pulse.
  initial begin
    retire_t e;
    forever begin
      @(negedge clk);
      if (start_flag) begin
        acc_cyc = 0; acc_req = 0; acc_we = 0; acc_alu = 0; acc_rf = 0; acc_ir = 0;
        start_flag = 1'b0;
      end
      acc_cyc++;
      if (mem_req) acc_req++;
      if (mem_req && mem_we) acc_we++;
      if (mem_req && addr_sel) acc_alu++;
      if (rf_we) acc_rf++;
      if (ir_load) acc_ir++;
      if (pc_write) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_retire: got pc_write=1 expected no retire");
        end else begin
          e = exp_q.pop_front();
          checkOutput($sformatf("i%0d_pc_src", e.seq), int'(pc_src), e.pc_src);
          checkOutput($sformatf("i%0d_state", e.seq), int'(state), e.retire_state);
          checkOutput($sformatf("i%0d_instret", e.seq), int'(instret), e.instret_old);
          checkOutput($sformatf("i%0d_latency", e.seq), acc_cyc, e.latency);
          checkOutput($sformatf("i%0d_req_cycles", e.seq), acc_req, e.req_cyc);
          checkOutput($sformatf("i%0d_we_cycles", e.seq), acc_we, e.we_cyc);
          checkOutput($sformatf("i%0d_alu_addr_cycles", e.seq), acc_alu, e.alu_cyc);
          checkOutput($sformatf("i%0d_rf_we", e.seq), acc_rf, e.rf_cnt);
          checkOutput($sformatf("i%0d_ir_load", e.seq), acc_ir, e.ir_cnt);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish expected finish by 100000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state with all outputs low.
    #2;
    checkOutput("rst_state", int'(state), 0);
    checkOutput("rst_mem_req", int'(mem_req), 0);
    checkOutput("rst_pc_write", int'(pc_write), 0);
    checkOutput("rst_instret", int'(instret), 0);
    checkOutput("rst_fault", int'(fault), 0);
    checkOutput("rst_halted", int'(halted), 0);
    tick();
    rst_n = 1'b1;

    // ADDI, then the retire counter reads 1.
    applyStimulus(K_ALU, 0, 0, 1'b0, 1'b0);
    checkOutput("instret_after_addi", int'(instret), 1);
    // LW with three stalled memory cycles: 8 cycles total.
    applyStimulus(K_LOAD, 0, 3, 1'b0, 1'b0);
    applyStimulus(K_BRANCH, 0, 0, 1'b1, 1'b0);
    applyStimulus(K_BRANCH, 0, 0, 1'b0, 1'b0);
    applyStimulus(K_STORE, 0, 0, 1'b0, 1'b0);
    applyStimulus(K_JAL, 0, 0, 1'b0, 1'b0);
    // Ready on the last allowed fetch/memory cycle completes normally.
    applyStimulus(K_ALU, 3, 0, 1'b0, 1'b0);
    applyStimulus(K_LOAD, 0, 3, 1'b0, 1'b0);

    // Halt at fetch entry: no request even with ready high.
    halt_req = 1'b1;
    mem_ready = 1'b1;
    #1;
    checkOutput("halt_entry_req", int'(mem_req), 0);
    checkOutput("halt_entry_ir_load", int'(ir_load), 0);
    tick();
    checkOutput("halted_flag", int'(halted), 1);
    checkOutput("halted_state", int'(state), 5);
    checkOutput("halted_req", int'(mem_req), 0);
    tick();
    checkOutput("halted_held", int'(halted), 1);
    halt_req = 1'b0;
    mem_ready = 1'b0;
    tick();
    checkOutput("unhalt_state", int'(state), 0);
    checkOutput("unhalt_req", int'(mem_req), 1);
    applyStimulus(K_ALU, 0, 0, 1'b0, 1'b0);

    // Halt raised mid-store: the store retires first, then the core parks.
    applyStimulus(K_STORE, 0, 1, 1'b0, 1'b1);
    checkOutput("halt_after_sw_instret", int'(instret), 10);
    checkOutput("halt_after_sw_req", int'(mem_req), 0);
    tick();
    checkOutput("halt_after_sw_halted", int'(halted), 1);
    halt_req = 1'b0;
    tick();
    checkOutput("halt_after_sw_resume", int'(state), 0);

    // Six more retirements bring a 4-bit counter back to zero.
    for (int i = 0; i < 6; i++) applyStimulus(K_ALU, 0, 0, 1'b0, 1'b0);
    checkOutput("instret_wrap", int'(instret), 0);

    // Memory never answers a fetch: fault after exactly four request cycles.
    mem_ready = 1'b0;
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      @(negedge clk);
      checkOutput($sformatf("timeout_req%0d", i), int'(mem_req), 1);
      tick();
    end
    checkOutput("timeout_state", int'(state), 6);
    checkOutput("timeout_fault", int'(fault), 1);
    mem_ready = 1'b1;
    tick(); tick(); tick();
    checkOutput("fault_sticky", int'(fault), 1);
    checkOutput("fault_no_req", int'(mem_req), 0);
    rst_n = 1'b0;
    mem_ready = 1'b0;
    #1;
    checkOutput("fault_rst_state", int'(state), 0);
    checkOutput("fault_rst_fault", int'(fault), 0);
    checkOutput("fault_rst_instret", int'(instret), 0);
    retired = 0;
    tick();
    rst_n = 1'b1;

    // Illegal opcode in decode faults.
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    illegal = 1'b1;
    tick();
    illegal = 1'b0;
    checkOutput("illegal_state", int'(state), 6);
    checkOutput("illegal_fault", int'(fault), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // Reset in the middle of a stalled fetch drops the request at once.
    tick();
    @(negedge clk);
    checkOutput("midreq_req_before", int'(mem_req), 1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreq_req_dropped", int'(mem_req), 0);
    tick();
    rst_n = 1'b1;
    applyStimulus(K_ALU, 0, 0, 1'b0, 1'b0);

    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
